muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes operands and control from the ID/EX pipeline register.
- Owns the HI/LO architectural registers and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Drives a stall request that freezes the upstream pipeline registers (write-enable low) whenever an instruction needs HI/LO, or the unit itself, while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- flush_i  input  1  abort any in-flight operation.
- start_i  input  1  EX instruction is MULT/MULTU/DIV/DIVU.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a_i  input  WIDTH  multiplicand / dividend (rs).
- src_b_i  input  WIDTH  multiplier / divisor (rt).
- hilo_rd_i  input  1  EX instruction is MFHI/MFLO.
- hi_we_i  input  1  MTHI in EX.
- lo_we_i  input  1  MTLO in EX.
- wdata_i  input  WIDTH  MTHI/MTLO data.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.
- busy_o  output  1  operation in flight.
- done_o  output  1  one-cycle pulse when a new result is visible.
- stall_o  output  1  hold upstream pipe regs.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, and hi_o, lo_o, busy_o, done_o, counter and internal operands all go to 0 immediately, with no clock edge required. Reset asserted mid-operation discards the operation.
- States:
  - IDLE: busy_o=0.
    - start_i=1 and flush_i=0: latch operands, record signs, convert signed operands (MULT/DIV) to magnitudes, clear counter, go to CALC.
    - Otherwise: hi_we_i writes HI and lo_we_i writes LO from wdata_i at the edge. If start_i and a write coincide, start_i wins and the writes are ignored.
  - CALC: busy_o=1. One radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) for exactly WIDTH cycles, then go to FIX.
  - FIX: busy_o=1. Apply sign correction:
    - Signed product: negate the 2*WIDTH product if the operand signs differ.
    - Signed quotient: negate if the operand signs differ.
    - Remainder: takes the sign of the dividend.
    - Write HI=upper/remainder, LO=lower/quotient. Set done_o=1 for the next cycle and go to IDLE.
- Latency: busy_o is high for WIDTH+1 cycles (33 cycles at WIDTH=32), starting the cycle after start_i is accepted. New HI/LO values first appear in the same cycle done_o is high.
- done_o is registered, high for exactly one cycle, otherwise 0.
- stall_o = busy_o & (start_i | hilo_rd_i | hi_we_i | lo_we_i). It is combinational, and 0 in the done_o cycle. While busy, start_i and MTHI/MTLO are ignored; upstream holds the instruction and re-presents it.
- flush_i:
  - In CALC or FIX: go to IDLE at the next edge. HI/LO are unchanged and no done_o pulse occurs.
  - In IDLE with start_i: start_i is not accepted. MTHI/MTLO are also suppressed.
- Divide by zero: LO=all ones, HI=src_a_i (both signed and unsigned).
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- All arithmetic is modulo 2^WIDTH per register. The multiply accumulator is 2*WIDTH bits. The divide remainder register is WIDTH+1 bits.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, FIX);
  - the counter width constant, $clog2(WIDTH+1).
- One natural sub-module: muldiv_sign_fix. It is combinational and does the magnitude conversion on entry and the result negation in FIX. It is instantiated once for the operands and once for the result.
- The FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 -> after 33 busy cycles, done_o=1 with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- hilo_rd_i held high from the cycle after a MULT start -> stall_o=1 for 33 cycles, 0 in the done_o cycle. A second start_i during busy is ignored, with HI/LO set only by the first operation.
- flush_i pulsed in CALC cycle 10 of a DIV with HI=0x11, LO=0x22 -> busy_o=0 the next cycle, HI/LO stay 0x11/0x22, done_o never pulses. MTLO 0x55 in IDLE -> LO=0x55 after one edge.
- rst_i asserted asynchronously between clock edges mid-CALC -> busy_o, hi_o, lo_o, done_o become 0 before the next edge. After release, the unit is in IDLE and accepts a new start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // Counter must hold values up to WIDTH
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(32);

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: either two independent WIDTH-bit
// lanes, or one 2*WIDTH value formed by {hi_i, lo_i} (negated by neg_lo_i).
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             wide_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] wide_val;

  always_comb begin
    wide_val = {hi_i, lo_i};
    if (wide_i) begin
      if (neg_lo_i) wide_val = -wide_val;
      hi_o = wide_val[2*WIDTH-1:WIDTH];
      lo_o = wide_val[WIDTH-1:0];
    end else begin
      hi_o = neg_hi_i ? -hi_i : hi_i;
      lo_o = neg_lo_i ? -lo_i : lo_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline
// stall generation while an operation is in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             hilo_rd_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               in_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic               is_mul_q;
  logic               signed_q;
  logic               div_by_zero;
  logic               res_neg_hi;
  logic               res_neg_lo;
  logic [WIDTH-1:0]   res_hi_in;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   rem_diff;

  assign in_signed = ~op_i[0];
  assign in_neg_a  = in_signed & src_a_i[WIDTH-1];
  assign in_neg_b  = in_signed & src_b_i[WIDTH-1];

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
    .wide_i   (1'b0),
    .neg_hi_i (in_neg_a),
    .neg_lo_i (in_neg_b),
    .hi_i     (src_a_i),
    .lo_i     (src_b_i),
    .hi_o     (mag_a),
    .lo_o     (mag_b)
  );

  // A zero divisor leaves quotient all ones; only the remainder keeps the
  // dividend sign, which reproduces the original dividend in HI.
  assign is_mul_q    = ~op_q[1];
  assign signed_q    = ~op_q[0];
  assign div_by_zero = (b_q == '0);
  assign res_neg_hi  = signed_q & sign_a_q;
  assign res_neg_lo  = signed_q & (sign_a_q ^ sign_b_q) & (is_mul_q | ~div_by_zero);
  assign res_hi_in   = is_mul_q ? acc_q[2*WIDTH-1:WIDTH] : rem_q[WIDTH-1:0];

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .wide_i   (is_mul_q),
    .neg_hi_i (res_neg_hi),
    .neg_lo_i (res_neg_lo),
    .hi_i     (res_hi_in),
    .lo_i     (acc_q[WIDTH-1:0]),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign rem_shift = {rem_q, acc_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {2'b00, b_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (start_i) begin
            state_d  = CALC;
            op_d     = op_i;
            cnt_d    = '0;
            sign_a_d = in_neg_a;
            sign_b_d = in_neg_b;
            a_d      = mag_a;
            b_d      = mag_b;
            acc_d    = op_i[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            rem_d    = '0;
          end else begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (is_mul_q) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else if (!rem_diff[WIDTH+1]) begin
            rem_d = rem_diff[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush_i) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o & (start_i | hilo_rd_i | hi_we_i | lo_we_i);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected HI/LO,
// a negedge monitor pops and compares on every done_o pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        hilo_rd_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  vec_t vecs [9] = '{
    '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA},
    '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
    '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
    '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E}
  };

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .src_a_i   (src_a_i),
    .src_b_i   (src_b_i),
    .hilo_rd_i (hilo_rd_i),
    .hi_we_i   (hi_we_i),
    .lo_we_i   (lo_we_i),
    .wdata_i   (wdata_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .stall_o   (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result_hi", hi_o, e.hi);
        checkOutput("result_lo", lo_o, e.lo);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic expect_result, input logic [31:0] ehi,
                               input logic [31:0] elo);
    exp_t e;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    start_i = 1'b1;
    if (expect_result) begin
      e.hi = ehi;
      e.lo = elo;
      sb.push_back(e);
    end
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic waitDone(output int busy_cnt);
    bit got;
    got      = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done_o) got = 1'b1;
      else begin
        if (busy_o) busy_cnt++;
        @(negedge clk_i);
      end
    end
    if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic writeHiLo(input logic hwe, input logic lwe, input logic [31:0] data);
    hi_we_i = hwe;
    lo_we_i = lwe;
    wdata_i = data;
    @(negedge clk_i);
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int stall_cnt;
    bit got;

    rst_i     = 1'b1;
    flush_i   = 1'b0;
    start_i   = 1'b0;
    op_i      = 2'b00;
    src_a_i   = '0;
    src_b_i   = '0;
    hilo_rd_i = 1'b0;
    hi_we_i   = 1'b0;
    lo_we_i   = 1'b0;
    wdata_i   = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_hi", hi_o, 32'd0);
    checkOutput("reset_lo", lo_o, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo);
      waitDone(busy_cnt);
      checkOutput($sformatf("busy_cycles_vec%0d", i), busy_cnt, 32'd33);
      @(negedge clk_i);
    end

    // Stall while HI/LO is read during busy; a held second start is ignored
    applyStimulus(OP_MULT, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30);
    op_i      = OP_MULTU;
    src_a_i   = 32'd7;
    src_b_i   = 32'd7;
    start_i   = 1'b1;
    hilo_rd_i = 1'b1;
    #1;
    stall_cnt = 0;
    got       = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done_o) got = 1'b1;
      else begin
        if (stall_o) stall_cnt++;
        @(negedge clk_i);
        #1;
      end
    end
    if (!got) checkOutput("stall_done_timeout", 32'd0, 32'd1);
    checkOutput("stall_cycles", stall_cnt, 32'd33);
    checkOutput("stall_in_done_cycle", {31'd0, stall_o}, 32'd0);
    start_i   = 1'b0;
    hilo_rd_i = 1'b0;
    repeat (40) @(negedge clk_i);
    checkOutput("second_start_ignored_lo", lo_o, 32'd30);
    checkOutput("second_start_ignored_busy", {31'd0, busy_o}, 32'd0);

    // Flush in CALC cycle 10 leaves HI/LO untouched and no done pulse
    writeHiLo(1'b1, 1'b0, 32'h11);
    writeHiLo(1'b0, 1'b1, 32'h22);
    checkOutput("mthi_value", hi_o, 32'h11);
    checkOutput("mtlo_value", lo_o, 32'h22);
    applyStimulus(OP_DIV, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flush_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("flush_hi", hi_o, 32'h11);
    checkOutput("flush_lo", lo_o, 32'h22);
    repeat (40) @(negedge clk_i);

    // Flush in IDLE blocks both the start and the coincident MTLO
    op_i    = OP_MULTU;
    start_i = 1'b1;
    flush_i = 1'b1;
    lo_we_i = 1'b1;
    wdata_i = 32'h99;
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    lo_we_i = 1'b0;
    checkOutput("idle_flush_no_start", {31'd0, busy_o}, 32'd0);
    checkOutput("idle_flush_no_mtlo", lo_o, 32'h22);
    writeHiLo(1'b0, 1'b1, 32'h55);
    checkOutput("mtlo_55", lo_o, 32'h55);

    // Start wins over a coincident MTHI
    hi_we_i = 1'b1;
    wdata_i = 32'hAB;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    hi_we_i = 1'b0;
    waitDone(busy_cnt);
    checkOutput("busy_cycles_coincide", busy_cnt, 32'd33);
    @(negedge clk_i);

    // Asynchronous reset mid-CALC, between clock edges
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (5) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("async_rst_hi", hi_o, 32'd0);
    checkOutput("async_rst_lo", lo_o, 32'd0);
    checkOutput("async_rst_done", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(OP_MULTU, 32'd9, 32'd9, 1'b1, 32'd0, 32'd81);
    waitDone(busy_cnt);
    checkOutput("busy_cycles_after_rst", busy_cnt, 32'd33);
    repeat (3) @(negedge clk_i);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
